// File: rtl/stsystem_tx.sv
// Serial transmitter: frames a parallel byte as start(0), data LSB-first, optional parity, stop(1).
// Bit timing comes from an internal baud counter; en=0 freezes the frame in place.
module stsystem_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DW           = 8,
  parameter int PAR_EN       = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          st,
  input  logic          opn,
  input  logic [DW-1:0] d,
  output logic          TX,
  output logic          RDY,
  output logic          BSY,
  output logic          DONE
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DW > 1) ? $clog2(DW) : 1;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DW-1:0] shreg;
  logic [DW-1:0] dlat;
  logic [DW-1:0] shnext;
  logic          opnl;
  logic          tx;
  logic          rdy;
  logic          done;
  logic          bitend;
  logic          parbit;

  assign shnext = shreg >> 1;
  assign bitend = (cnt == CW'(CLKS_PER_BIT - 1));
  // Parity uses the copy latched at accept time, never the live d input.
  assign parbit = opnl ? ~^dlat : ^dlat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      dlat  <= '0;
      opnl  <= 1'b0;
      tx    <= 1'b1;
      rdy   <= 1'b1;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (st) begin
              shreg <= d;
              dlat  <= d;
              opnl  <= opn;
              cnt   <= '0;
              idx   <= '0;
              tx    <= 1'b0;
              rdy   <= 1'b0;
              state <= START;
            end
          end
          START: begin
            if (bitend) begin
              cnt   <= '0;
              idx   <= '0;
              tx    <= shreg[0];
              state <= DATA;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DATA: begin
            if (bitend) begin
              cnt   <= '0;
              shreg <= shnext;
              if (idx == IW'(DW - 1)) begin
                if (PAR_EN != 0) begin
                  tx    <= parbit;
                  state <= PARITY;
                end else begin
                  tx    <= 1'b1;
                  state <= STOP;
                end
              end else begin
                idx <= idx + IW'(1);
                tx  <= shnext[0];
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          PARITY: begin
            if (bitend) begin
              cnt   <= '0;
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          STOP: begin
            // Returning to IDLE and raising RDY on the same edge lets st be taken in the DONE cycle.
            if (bitend) begin
              cnt   <= '0;
              tx    <= 1'b1;
              rdy   <= 1'b1;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            cnt   <= '0;
            tx    <= 1'b1;
            rdy   <= 1'b1;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign TX   = tx;
  assign RDY  = rdy;
  assign BSY  = ~rdy;
  assign DONE = done;

endmodule

// File: tb/tb_stsystem_tx.sv
// Directed bench for stsystem_tx with CLKS_PER_BIT=4, DW=8; one instance with parity, one without.
// Expected frames are hand-written bit vectors, bit 0 = start bit.
module tb_stsystem_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       st;
  logic       opn;
  logic [7:0] d;
  logic       st0;
  logic [7:0] d0;
  logic       tx, rdy, bsy, done;
  logic       tx0, rdy0, bsy0, done0;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  stsystem_tx #(.CLKS_PER_BIT(4), .DW(8), .PAR_EN(1)) dut (
    .clk(clk), .rst(rst), .en(en), .st(st), .opn(opn), .d(d),
    .TX(tx), .RDY(rdy), .BSY(bsy), .DONE(done)
  );

  stsystem_tx #(.CLKS_PER_BIT(4), .DW(8), .PAR_EN(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .st(st0), .opn(opn), .d(d0),
    .TX(tx0), .RDY(rdy0), .BSY(bsy0), .DONE(done0)
  );

  task tick;
    @(posedge clk);
    #1;
  endtask

  task applyStimulus(input logic s, input logic o, input logic [7:0] dv);
    st  = s;
    opn = o;
    d   = dv;
  endtask

  // Observed word is {TX, DONE, RDY, BSY}.
  function automatic logic [3:0] outs(input bit sel);
    return sel ? {tx0, done0, rdy0, bsy0} : {tx, done, rdy, bsy};
  endfunction

  task checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed {TX,DONE,RDY,BSY}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Called one cycle after the accept edge; each frame bit lasts 4 enabled cycles.
  task checkBits(input string tag, input logic [10:0] bits, input int ncyc,
                 input int stallAt, input bit sel);
    for (int j = 0; j < ncyc; j++) begin
      checkOutput(tag, outs(sel), {bits[j/4], 3'b001});
      if (j == stallAt) begin
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick;
          checkOutput({tag, "_stall"}, outs(sel), {bits[j/4], 3'b001});
        end
        en = 1'b1;
      end
      tick;
    end
  endtask

  task checkDone(input string tag, input bit sel);
    checkOutput(tag, outs(sel), 4'b1110);
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    st0 = 1'b0;
    d0  = 8'h00;
    applyStimulus(1'b0, 1'b0, 8'h00);

    // Reset and idle hold
    tick;
    tick;
    checkOutput("reset", outs(0), 4'b1010);
    checkOutput("reset_np", outs(1), 4'b1010);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("idle_hold", outs(0), 4'b1010);
    end

    // A5, even parity: 0,1,0,1,0,0,1,0,1,0,1
    applyStimulus(1'b1, 1'b0, 8'hA5);
    tick;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkBits("a5_even", 11'h54A, 44, -1, 0);
    checkDone("a5_done", 0);
    tick;
    checkOutput("a5_after", outs(0), 4'b1010);

    // 01, odd parity -> parity 0; d and opn changed mid-frame
    applyStimulus(1'b1, 1'b1, 8'h01);
    tick;
    applyStimulus(1'b0, 1'b0, 8'hFE);
    checkBits("01_odd", 11'h402, 44, -1, 0);
    checkDone("01_odd_done", 0);
    tick;

    // 01, even parity -> parity 1
    applyStimulus(1'b1, 1'b0, 8'h01);
    tick;
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkBits("01_even", 11'h602, 44, -1, 0);
    checkDone("01_even_done", 0);
    tick;

    // st held high: back-to-back frames, second captures d at the DONE-cycle edge
    applyStimulus(1'b1, 1'b0, 8'hA5);
    tick;
    applyStimulus(1'b1, 1'b0, 8'h01);
    checkBits("b2b_1", 11'h54A, 44, -1, 0);
    checkDone("b2b_1_done", 0);
    tick;
    checkBits("b2b_2", 11'h602, 44, -1, 0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkDone("b2b_2_done", 0);
    tick;
    checkOutput("b2b_after", outs(0), 4'b1010);

    // en low 3 cycles in data bit 2: that bit lasts 7 cycles
    applyStimulus(1'b1, 1'b0, 8'hA5);
    tick;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkBits("stall", 11'h54A, 44, 13, 0);
    checkDone("stall_done", 0);
    tick;

    // Reset during the parity bit aborts without DONE
    applyStimulus(1'b1, 1'b0, 8'h01);
    tick;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkBits("abort_pre", 11'h602, 38, -1, 0);
    rst = 1'b0;
    tick;
    checkOutput("abort_reset", outs(0), 4'b1010);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      checkOutput("abort_nodone", outs(0), 4'b1010);
    end

    // No-parity instance, FF: 10-bit frame, DONE at 40 cycles
    st0 = 1'b1;
    d0  = 8'hFF;
    tick;
    st0 = 1'b0;
    d0  = 8'h00;
    checkBits("np_ff", 11'h3FE, 40, -1, 1);
    checkDone("np_ff_done", 1);
    tick;
    checkOutput("np_after", outs(1), 4'b1010);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
